// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared 7-segment glyph constants and capture FSM state type
package seg_pkg;

  localparam logic [7:0] NUM_0   = 8'hC0;
  localparam logic [7:0] NUM_1   = 8'hF9;
  localparam logic [7:0] NUM_2   = 8'hA4;
  localparam logic [7:0] NUM_3   = 8'hB0;
  localparam logic [7:0] NUM_4   = 8'h99;
  localparam logic [7:0] NUM_5   = 8'h92;
  localparam logic [7:0] NUM_6   = 8'h82;
  localparam logic [7:0] NUM_7   = 8'hF8;
  localparam logic [7:0] NUM_8   = 8'h80;
  localparam logic [7:0] NUM_9   = 8'h90;
  localparam logic [7:0] NUM_ERR = 8'h86;

  localparam logic [3:0] ERR_CODE = 4'hE;
  localparam logic [3:0] BAD_CODE = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_HOLD
  } cap_state_e;

endpackage

// File: rtl/seg_pattern_dec.sv
// rtl/seg_pattern_dec.sv - combinational segment pattern to digit code decoder
module seg_pattern_dec
  import seg_pkg::*;
#(
  parameter int SEG_WID = 8
) (
  input  logic [SEG_WID-1:0] pattern,
  output logic [3:0]         code,
  output logic               known
);

  // Full-width match: a lit decimal point makes the glyph unknown.
  always_comb begin
    code  = BAD_CODE;
    known = 1'b1;
    case (pattern)
      SEG_WID'(NUM_0):   code = 4'd0;
      SEG_WID'(NUM_1):   code = 4'd1;
      SEG_WID'(NUM_2):   code = 4'd2;
      SEG_WID'(NUM_3):   code = 4'd3;
      SEG_WID'(NUM_4):   code = 4'd4;
      SEG_WID'(NUM_5):   code = 4'd5;
      SEG_WID'(NUM_6):   code = 4'd6;
      SEG_WID'(NUM_7):   code = 4'd7;
      SEG_WID'(NUM_8):   code = 4'd8;
      SEG_WID'(NUM_9):   code = 4'd9;
      SEG_WID'(NUM_ERR): code = ERR_CODE;
      default:           known = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_capture.sv
// rtl/seg_capture.sv - recovers per-digit codes from a multiplexed 7-segment bus
module seg_capture
  import seg_pkg::*;
#(
  parameter int SEG_NUM    = 8,
  parameter int SEG_WID    = 8,
  parameter int STABLE_CYC = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [SEG_NUM-1:0]   seg_sel,
  input  logic [SEG_WID-1:0]   segment,
  output logic [SEG_NUM*4-1:0] dout,
  output logic [SEG_NUM-1:0]   dout_vld,
  output logic                 frame_done,
  output logic                 sel_err,
  output logic                 pat_err
);

  localparam int         W          = SEG_NUM + SEG_WID;
  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYC);

  logic [W-1:0]         sync1_q, sync2_q, prev_q;
  logic [7:0]           cnt_q, cnt_d;
  cap_state_e           state_q, state_d;
  logic [SEG_NUM*4-1:0] dout_q, dout_d;
  logic [SEG_NUM-1:0]   dout_vld_q, dout_vld_d;
  logic [SEG_NUM-1:0]   seen_q, seen_d;
  logic                 frame_done_q, frame_done_d;
  logic                 sel_err_q, sel_err_d;
  logic                 pat_err_q, pat_err_d;

  logic [SEG_NUM-1:0]   sel_act;
  logic [SEG_WID-1:0]   pat;
  logic                 chg;
  logic                 multi;
  logic                 sample;
  logic [3:0]           code;
  logic                 known;

  assign sel_act = ~sync2_q[W-1 -: SEG_NUM];
  assign pat     = sync2_q[SEG_WID-1:0];
  assign chg     = (sync2_q != prev_q);
  assign multi   = ((sel_act & (sel_act - SEG_NUM'(1))) != '0);

  seg_pattern_dec #(
    .SEG_WID (SEG_WID)
  ) u_dec (
    .pattern (pat),
    .code    (code),
    .known   (known)
  );

  always_comb begin
    cnt_d = cnt_q;
    if (chg) begin
      cnt_d = '0;
    end else if (cnt_q != STABLE_MAX) begin
      cnt_d = cnt_q + 8'd1;
    end

    // Sampling only from SETTLE guarantees a held word is captured once.
    sample  = (state_q == ST_SETTLE) && !chg && (cnt_d == STABLE_MAX);
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (chg) state_d = ST_SETTLE;
      ST_SETTLE: if (sample) state_d = ST_HOLD;
      ST_HOLD:   if (chg) state_d = ST_SETTLE;
      default:   state_d = ST_IDLE;
    endcase

    dout_d       = dout_q;
    seen_d       = seen_q;
    dout_vld_d   = '0;
    frame_done_d = 1'b0;
    sel_err_d    = 1'b0;
    pat_err_d    = 1'b0;
    if (sample && (sel_act != '0)) begin
      if (multi) begin
        sel_err_d = 1'b1;
      end else begin
        for (int i = 0; i < SEG_NUM; i++) begin
          if (sel_act[i]) begin
            dout_d[4*i +: 4] = code;
            dout_vld_d[i]    = 1'b1;
          end
        end
        pat_err_d = !known;
        seen_d    = seen_q | sel_act;
        if (&seen_d) begin
          frame_done_d = 1'b1;
          seen_d       = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= '1;
      sync2_q      <= '1;
      prev_q       <= '1;
      cnt_q        <= '0;
      state_q      <= ST_IDLE;
      dout_q       <= '0;
      dout_vld_q   <= '0;
      seen_q       <= '0;
      frame_done_q <= 1'b0;
      sel_err_q    <= 1'b0;
      pat_err_q    <= 1'b0;
    end else begin
      sync1_q      <= {seg_sel, segment};
      sync2_q      <= sync1_q;
      prev_q       <= sync2_q;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      dout_q       <= dout_d;
      dout_vld_q   <= dout_vld_d;
      seen_q       <= seen_d;
      frame_done_q <= frame_done_d;
      sel_err_q    <= sel_err_d;
      pat_err_q    <= pat_err_d;
    end
  end

  assign dout       = dout_q;
  assign dout_vld   = dout_vld_q;
  assign frame_done = frame_done_q;
  assign sel_err    = sel_err_q;
  assign pat_err    = pat_err_q;

endmodule

// File: tb/tb_seg_capture.sv
// tb/tb_seg_capture.sv - scoreboard bench for seg_capture
module tb_seg_capture;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  seg_sel = 8'hFF;
  logic [7:0]  segment = 8'hFF;
  logic [31:0] dout;
  logic [7:0]  dout_vld;
  logic        frame_done, sel_err, pat_err;

  seg_capture #(
    .SEG_NUM    (8),
    .SEG_WID    (8),
    .STABLE_CYC (S)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg_sel    (seg_sel),
    .segment    (segment),
    .dout       (dout),
    .dout_vld   (dout_vld),
    .frame_done (frame_done),
    .sel_err    (sel_err),
    .pat_err    (pat_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [7:0]  vld;
    logic [31:0] dout;
    logic        fd;
    logic        se;
    logic        pe;
  } ev_t;

  ev_t exp_q[$];
  ev_t got_e;
  int  checks = 0;
  int  errors = 0;

  logic [31:0] m_dout = '0;
  logic [7:0]  m_seen = '0;
  logic [15:0] m_prev = 16'hFFFF;
  logic [7:0]  seg_tab [8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] ref_dec(input logic [7:0] p);
    case (p)
      8'hC0: return 4'd0;
      8'hF9: return 4'd1;
      8'hA4: return 4'd2;
      8'hB0: return 4'd3;
      8'h99: return 4'd4;
      8'h92: return 4'd5;
      8'h82: return 4'd6;
      8'hF8: return 4'd7;
      8'h80: return 4'd8;
      8'h90: return 4'd9;
      8'h86: return 4'hE;
      default: return 4'hF;
    endcase
  endfunction

  // Drive a word for ncyc cycles; push the expected output event if it should capture.
  task automatic drive(input logic [7:0] sel, input logic [7:0] seg, input int ncyc);
    ev_t e;
    int  zeros;
    int  idx;
    @(posedge clk);
    #1;
    seg_sel = sel;
    segment = seg;
    if (ncyc >= S + 1 && {sel, seg} != m_prev) begin
      zeros = 0;
      idx   = 0;
      for (int i = 0; i < 8; i++) begin
        if (!sel[i]) begin
          zeros++;
          idx = i;
        end
      end
      e.cyc = cyc + S + 3;
      e.vld = '0;
      e.fd  = 1'b0;
      e.se  = 1'b0;
      e.pe  = 1'b0;
      if (zeros == 1) begin
        m_dout[4*idx +: 4] = ref_dec(seg);
        e.vld       = 8'(1 << idx);
        e.pe        = (ref_dec(seg) == 4'hF);
        m_seen[idx] = 1'b1;
        if (m_seen == 8'hFF) begin
          e.fd   = 1'b1;
          m_seen = '0;
        end
      end else if (zeros > 1) begin
        e.se = 1'b1;
      end
      e.dout = m_dout;
      if (zeros > 0) exp_q.push_back(e);
    end
    m_prev = {sel, seg};
    repeat (ncyc - 1) @(posedge clk);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    seg_sel = 8'hFF;
    segment = 8'hFF;
    m_dout  = '0;
    m_seen  = '0;
    m_prev  = 16'hFFFF;
    repeat (3) begin
      @(negedge clk);
      check("rst_dout", dout, 32'h0);
      check("rst_pulses", {21'd0, dout_vld, frame_done, sel_err, pat_err}, 32'h0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic digits(input int n);
    logic [7:0] sel;
    for (int i = 0; i < n; i++) begin
      sel = ~(8'd1 << i);
      drive(sel, seg_tab[i], 10);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && (dout_vld != '0 || frame_done || sel_err || pat_err)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {21'd0, dout_vld, frame_done, sel_err, pat_err}, 32'h0);
      end else begin
        got_e = exp_q.pop_front();
        check("latency_cyc", cyc, got_e.cyc);
        check("dout_vld", {24'd0, dout_vld}, {24'd0, got_e.vld});
        check("dout", dout, got_e.dout);
        check("frame_done", {31'd0, frame_done}, {31'd0, got_e.fd});
        check("sel_err", {31'd0, sel_err}, {31'd0, got_e.se});
        check("pat_err", {31'd0, pat_err}, {31'd0, got_e.pe});
      end
    end
  end

  initial begin
    do_reset();
    // rotation scan
    drive(8'hFE, 8'hA4, 10);
    drive(8'hFD, 8'hB0, 10);
    // full frame
    digits(8);
    @(negedge clk);
    check("frame_dout", dout, 32'h7654_3210);
    // glitch rejection
    drive(8'hFE, 8'hC0, 10);
    drive(8'hFE, 8'hF9, 2);
    drive(8'hFE, 8'hC0, 10);
    // error cases
    drive(8'hFC, 8'hC0, 10);
    drive(8'hFB, 8'h86, 10);
    drive(8'hFB, 8'hFF, 10);
    // blank then long hold
    drive(8'hFF, 8'hFF, 50);
    drive(8'hFE, 8'h99, 100);
    // reset mid-frame
    digits(4);
    check("pending_pre_reset", exp_q.size(), 32'd0);
    do_reset();
    digits(8);
    drive(8'hFF, 8'hFF, 20);
    check("pending_end", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
